// File: rtl/fetch_queue_unit.sv
// ---------------------------------------------------------------------------
// fetch_queue_unit
//
// Purpose:
//   Fetch front end with a circular instruction queue of 2**IQ_WIDTH entries.
//   It generates the PC and requests instructions from the icache. It
//   redirects on JAL and predicted-taken branches. It stalls on JALR until
//   the target resolves. It empties the queue and redirects when the reorder
//   buffer flushes. Decode pops the head entry with a valid/ready handshake.
//
// Configuration macro:
//   IU_BRANCH_PREDICT_EN - when defined, conditional branches follow the
//                          'jump' hint. When undefined, branches are static
//                          not-taken: PC+4, and the recorded prediction is 0.
//
// Ports:
//   clockIn, resetIn            clock; synchronous active-high reset
//   instrInValid/instrIn/instrAddr  icache response (word + its address)
//   fetchValid/fetchAddr        fetch request to the icache (addr = PC)
//   jump                        predictor taken hint for the returned branch
//   jalrReady/jalrTarget        resolved JALR target
//   flushIn/flushPC             misprediction redirect
//   issueReady/issueValid       decode handshake on the queue head
//   issueInstr/issuePC/issuePredTaken  head entry (zero when empty)
//   iqCount                     queue occupancy
//   fsmStateDbg                 current FSM state (0 = FETCH, 1 = WAIT_JALR)
//
// Handshakes:
//   An icache response is consumed only in a cycle with fetchValid=1 and
//   instrAddr==fetchAddr. Decode pops the head on a rising edge where
//   issueValid && issueReady. issueValid does not depend on issueReady.
// ---------------------------------------------------------------------------
module fetch_queue_unit #(
  parameter int          ROB_WIDTH = 4,
  parameter int          IQ_WIDTH  = 3,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic              clockIn,
  input  logic              resetIn,
  input  logic              instrInValid,
  input  logic [31:0]       instrIn,
  input  logic [31:0]       instrAddr,
  output logic              fetchValid,
  output logic [31:0]       fetchAddr,
  input  logic              jump,
  input  logic              jalrReady,
  input  logic [31:0]       jalrTarget,
  input  logic              flushIn,
  input  logic [31:0]       flushPC,
  input  logic              issueReady,
  output logic              issueValid,
  output logic [31:0]       issueInstr,
  output logic [31:0]       issuePC,
  output logic              issuePredTaken,
  output logic [IQ_WIDTH:0] iqCount,
  output logic              fsmStateDbg
);

  localparam int                DEPTH     = 2 ** IQ_WIDTH;
  localparam logic [IQ_WIDTH:0] DEPTH_CNT = (IQ_WIDTH + 1)'(DEPTH);

  // ROB_WIDTH is carried for interface consistency with the rest of the core.
  localparam int unused_rob_width = ROB_WIDTH;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic {
    ST_FETCH     = 1'b0,
    ST_WAIT_JALR = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [IQ_WIDTH-1:0] head_q, head_d;
  logic [IQ_WIDTH-1:0] tail_q, tail_d;
  logic [IQ_WIDTH:0]   count_q, count_d;

  logic [31:0] instr_mem_q [DEPTH];
  logic [31:0] pc_mem_q    [DEPTH];
  logic        taken_mem_q [DEPTH];

  logic        full, empty, accept, pop, push;
  logic        push_taken, branch_taken;
  logic [6:0]  opcode;
  logic [31:0] j_imm, b_imm;

  // The low bit of a JALR target is always cleared, and 'jump' is unused
  // when branch prediction is compiled out.
  logic unused_inputs;
  assign unused_inputs = ^{jalrTarget[0], jump};

  assign opcode = instrIn[6:0];
  assign j_imm  = {{11{instrIn[31]}}, instrIn[31], instrIn[19:12], instrIn[20],
                   instrIn[30:21], 1'b0};
  assign b_imm  = {{19{instrIn[31]}}, instrIn[31], instrIn[7], instrIn[30:25],
                   instrIn[11:8], 1'b0};

`ifdef IU_BRANCH_PREDICT_EN
  assign branch_taken = jump;
`else
  assign branch_taken = 1'b0;
`endif

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    push       = 1'b0;
    push_taken = 1'b0;

    fetchValid = (state_q == ST_FETCH) && !full;
    // Responses for any address other than the current PC are stale
    // leftovers from before a redirect, so they are dropped.
    accept     = instrInValid && fetchValid && (instrAddr == pc_q);
    pop        = !empty && issueReady;

    case (state_q)
      ST_FETCH: begin
        if (accept) begin
          push = 1'b1;
          case (opcode)
            OP_JAL: begin
              pc_d       = pc_q + j_imm;
              push_taken = 1'b1;
            end
            OP_BRANCH: begin
              push_taken = branch_taken;
              pc_d       = branch_taken ? (pc_q + b_imm) : (pc_q + 32'd4);
            end
            OP_JALR: begin
              // Target is unknown until execute resolves it, so stop
              // fetching and keep the PC until it arrives.
              state_d = ST_WAIT_JALR;
            end
            default: pc_d = pc_q + 32'd4;
          endcase
        end
      end
      ST_WAIT_JALR: begin
        if (jalrReady) begin
          pc_d    = {jalrTarget[31:1], 1'b0};
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase

    if (push) tail_d = tail_q + IQ_WIDTH'(1);
    if (pop)  head_d = head_q + IQ_WIDTH'(1);
    if (push && !pop)      count_d = count_q + (IQ_WIDTH + 1)'(1);
    else if (pop && !push) count_d = count_q - (IQ_WIDTH + 1)'(1);

    // A flush discards everything in flight this cycle, including an accept
    // or a pop that would otherwise happen at this edge.
    if (flushIn) begin
      state_d = ST_FETCH;
      pc_d    = flushPC;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      push    = 1'b0;
    end
  end

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Queue storage needs no reset: entries are only observed while counted.
  always_ff @(posedge clockIn) begin
    if (push && !resetIn) begin
      instr_mem_q[tail_q] <= instrIn;
      pc_mem_q[tail_q]    <= pc_q;
      taken_mem_q[tail_q] <= push_taken;
    end
  end

  assign fetchAddr      = pc_q;
  assign issueValid     = !empty;
  assign issueInstr     = empty ? 32'h0 : instr_mem_q[head_q];
  assign issuePC        = empty ? 32'h0 : pc_mem_q[head_q];
  assign issuePredTaken = empty ? 1'b0  : taken_mem_q[head_q];
  assign iqCount        = count_q;
  assign fsmStateDbg    = state_q;

endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised fetch front end that replaces the single-register fetch stage with a circular instruction queue of 2^IQ_WIDTH entries. It generates the PC, redirects on JAL/branch prediction, stalls on JALR until the target resolves, and supports a full flush/redirect from the reorder buffer on misprediction. It sits between the icache and the decode/issue logic; decode pops entries with a valid/ready handshake.

## Interface
- ROB_WIDTH, 4, reorder buffer index width (kept for codebase consistency; sizes no ports here)
- IQ_WIDTH, 3, log2 of queue depth (depth 8)
- RESET_PC, 32'h0, PC loaded on reset
- clockIn  input  1  clock; all state updates on posedge
- resetIn  input  1  reset; synchronous, active-high
- instrInValid  input  1  icache response valid
- instrIn  input  32  icache instruction word
- instrAddr  input  32  address of returned instruction
- fetchValid  output  1  fetch request valid to icache
- fetchAddr  output  32  fetch address (current PC)
- jump  input  1  predictor taken hint for the branch currently returned
- jalrReady  input  1  JALR target resolved
- jalrTarget  input  32  resolved JALR target
- flushIn  input  1  misprediction redirect
- flushPC  input  32  redirect target
- issueReady  input  1  decode accepts head entry
- issueValid  output  1  queue non-empty
- issueInstr  output  32  head instruction
- issuePC  output  32  head instruction address
- issuePredTaken  output  1  prediction recorded for head
- iqCount  output  IQ_WIDTH+1  occupancy

## Operation
- States: FETCH, WAIT_JALR.
- fetchValid = (state==FETCH) && !full; fetchAddr = PC.
- Accept = instrInValid && fetchValid && instrAddr==PC. Responses with instrAddr!=PC are dropped (stale after redirect).
- On accept: push {instrIn, PC, taken} at tail; next PC by instrIn[6:0]:
  - 1101111 JAL: PC + J-imm (sign-extended {31,19:12,20,30:21,0}); taken=1.
  - 1100011 branch: taken=jump; PC + B-imm if taken else PC+4.
  - 1100111 JALR: PC unchanged, state→WAIT_JALR, taken=0.
  - others: PC+4, taken=0.
- WAIT_JALR: on jalrReady, PC ← {jalrTarget[31:1],0}, state→FETCH.
- Pop when issueValid && issueReady; head advances.
- Pointers IQ_WIDTH bits, wrap modulo depth; full = iqCount==2^IQ_WIDTH; empty = iqCount==0.
- Push blocked when full even if popping same cycle; push+pop on non-full, non-empty queue leaves iqCount unchanged.
- issueInstr/issuePC/issuePredTaken = head entry when non-empty, else 0.
- PC arithmetic modulo 2^32.

## Timing
- Reset (resetIn=1 at posedge): PC=RESET_PC, state=FETCH, pointers/count 0. Outputs after reset: fetchValid=1, fetchAddr=RESET_PC, issueValid=0, issueInstr=0, issuePC=0, issuePredTaken=0, iqCount=0. Reset overrides flush and all handshakes, including mid-WAIT_JALR.
- Accept at edge N: entry visible (issueValid=1) from cycle N+1; new fetchAddr from N+1. Sustained rate one instruction per cycle.
- Pop at edge N: next head visible N+1.
- jalrReady at edge N: fetchValid=1 with target from N+1.
- flushIn at edge N: queue emptied, PC=flushPC, state=FETCH from N+1; overrides same-cycle accept, pop and jalrReady. Responses returning for old addresses are dropped.

## Configuration
- IU_BRANCH_PREDICT_EN defined: branches follow jump as above.
- Undefined: jump ignored; branches always PC+4, issuePredTaken=0 for branches (static not-taken); JAL unchanged.

## Test plan
- Reset, icache returns ADDI at 0,4,8 back-to-back -> fetchAddr 0,4,8,12; issueValid from cycle 2; issuePC 0,4,8; iqCount 3 with issueReady=0.
- Fill 8 entries with issueReady=0 -> fetchValid=0, iqCount=8; 9th response ignored; assert issueReady one cycle -> iqCount 7, fetchValid=1.
- JAL at 0x10 imm +0x20 -> next fetchAddr 0x30, issuePredTaken=1; BEQ at 0x30 imm −8, jump=1 -> fetchAddr 0x28 (with macro), 0x34 without.
- JALR at 0x40 -> fetchValid=0 until jalrReady with jalrTarget=0x101 -> fetchAddr 0x100 next cycle.
- 5 entries queued, flushIn with flushPC=0x200 simultaneous with pop and accept -> iqCount 0, fetchAddr 0x200; late response instrAddr=0x44 dropped.
- Wrap: push/pop 20 instructions with issueReady toggling -> issuePC order strictly sequential, no loss or duplication.
